// File: rtl/indicator_driver.sv
// indicator_driver
//   Drives the four status LEDs and the active buzzer from single-cycle command
//   pulses issued by the control FSM. Each command selects a display mode: OFF and
//   ON are steady, ERR blinks fast and OPEN blinks slow. Each command also starts a
//   timed beep burst: ERR_BEEPS beeps for ERR and one beep for the other commands.
//   Timing is kept in timebase ticks of TICK_DIV clk_i cycles.
//
//   Ports
//     clk_i         system clock
//     reset_i       synchronous active-low reset
//     cmd_err_i     1-cycle pulse, enter ERR indication   (highest priority)
//     cmd_open_i    1-cycle pulse, enter OPEN indication
//     cmd_on_i      1-cycle pulse, enter ON indication
//     cmd_off_i     1-cycle pulse, enter OFF indication   (lowest priority)
//     led_err_o     fast blink while mode is ERR
//     led_off_o     steady while mode is OFF
//     led_on_o      steady while mode is ON
//     led_open_o    slow blink while mode is OPEN
//     buzzer_o      active-high buzzer drive
//     busy_o        high while a beep burst is in progress
//
//   Buzzer FSM
//     state   | meaning
//     ST_IDLE | no burst, buzzer low
//     ST_BEEP | buzzer high, counting BEEP_TICKS
//     ST_GAP  | buzzer low between beeps, counting GAP_TICKS
module indicator_driver #(
   parameter int TICK_DIV   = 50000,
   parameter int BEEP_TICKS = 100,
   parameter int GAP_TICKS  = 100,
   parameter int FAST_HALF  = 125,
   parameter int SLOW_HALF  = 500,
   parameter int ERR_BEEPS  = 3
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic cmd_err_i,
   input  logic cmd_off_i,
   input  logic cmd_on_i,
   input  logic cmd_open_i,
   output logic led_err_o,
   output logic led_off_o,
   output logic led_on_o,
   output logic led_open_o,
   output logic buzzer_o,
   output logic busy_o
);

   localparam int MAX_AB = (BEEP_TICKS > GAP_TICKS) ? BEEP_TICKS : GAP_TICKS;
   localparam int MAX_CD = (SLOW_HALF > FAST_HALF) ? SLOW_HALF : FAST_HALF;
   localparam int MAX_T  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int TW     = $clog2(MAX_T + 1);
   localparam int PW     = $clog2(TICK_DIV);

   typedef enum logic [1:0] {MODE_OFF, MODE_ON, MODE_OPEN, MODE_ERR} mode_e;
   typedef enum logic [1:0] {ST_IDLE, ST_BEEP, ST_GAP} buz_e;

   logic [PW-1:0] pre_q, pre_d;
   mode_e         mode_q, mode_d, cmd_mode;
   logic [TW-1:0] blink_cnt_q, blink_cnt_d;
   logic          phase_q, phase_d;
   buz_e          st_q, st_d;
   logic [3:0]    beeps_q, beeps_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic          led_err_q, led_off_q, led_on_q, led_open_q, buzzer_q, busy_q;
   logic          led_err_d, led_off_d, led_on_d, led_open_d, buzzer_d, busy_d;
   logic          tick, accept;
   logic [TW-1:0] half_last;

   always_comb begin
      tick   = (pre_q == PW'(TICK_DIV - 1));
      pre_d  = tick ? '0 : pre_q + PW'(1);
      accept = cmd_err_i | cmd_open_i | cmd_on_i | cmd_off_i;

      if (cmd_err_i)       cmd_mode = MODE_ERR;
      else if (cmd_open_i) cmd_mode = MODE_OPEN;
      else if (cmd_on_i)   cmd_mode = MODE_ON;
      else                 cmd_mode = MODE_OFF;

      // Blink timebase: a repeated command of the current mode must not disturb it.
      half_last   = (mode_q == MODE_ERR) ? TW'(FAST_HALF - 1) : TW'(SLOW_HALF - 1);
      mode_d      = mode_q;
      blink_cnt_d = blink_cnt_q;
      phase_d     = phase_q;
      if (accept && (cmd_mode != mode_q)) begin
         mode_d      = cmd_mode;
         blink_cnt_d = '0;
         phase_d     = 1'b1;
      end else if (tick && (mode_q == MODE_ERR || mode_q == MODE_OPEN)) begin
         if (blink_cnt_q == half_last) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + TW'(1);
         end
      end

      st_d    = st_q;
      beeps_d = beeps_q;
      tcnt_d  = tcnt_q;
      if (accept) begin
         // Restart straight into BEEP so an ongoing beep stays high without a glitch.
         st_d    = ST_BEEP;
         beeps_d = (cmd_mode == MODE_ERR) ? 4'(ERR_BEEPS) : 4'd1;
         tcnt_d  = '0;
      end else if (tick) begin
         case (st_q)
            ST_BEEP: begin
               if (tcnt_q == TW'(BEEP_TICKS - 1)) begin
                  tcnt_d  = '0;
                  beeps_d = beeps_q - 4'd1;
                  st_d    = (beeps_q == 4'd1) ? ST_IDLE : ST_GAP;
               end else begin
                  tcnt_d = tcnt_q + TW'(1);
               end
            end
            ST_GAP: begin
               if (tcnt_q == TW'(GAP_TICKS - 1)) begin
                  tcnt_d = '0;
                  st_d   = ST_BEEP;
               end else begin
                  tcnt_d = tcnt_q + TW'(1);
               end
            end
            default: ;
         endcase
      end

      led_err_d  = (mode_d == MODE_ERR) && phase_d;
      led_open_d = (mode_d == MODE_OPEN) && phase_d;
      led_on_d   = (mode_d == MODE_ON);
      led_off_d  = (mode_d == MODE_OFF);
      buzzer_d   = (st_d == ST_BEEP);
      busy_d     = (st_d != ST_IDLE);
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         pre_q       <= '0;
         mode_q      <= MODE_OFF;
         blink_cnt_q <= '0;
         phase_q     <= 1'b0;
         st_q        <= ST_IDLE;
         beeps_q     <= '0;
         tcnt_q      <= '0;
         led_err_q   <= 1'b0;
         led_off_q   <= 1'b1;
         led_on_q    <= 1'b0;
         led_open_q  <= 1'b0;
         buzzer_q    <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         pre_q       <= pre_d;
         mode_q      <= mode_d;
         blink_cnt_q <= blink_cnt_d;
         phase_q     <= phase_d;
         st_q        <= st_d;
         beeps_q     <= beeps_d;
         tcnt_q      <= tcnt_d;
         led_err_q   <= led_err_d;
         led_off_q   <= led_off_d;
         led_on_q    <= led_on_d;
         led_open_q  <= led_open_d;
         buzzer_q    <= buzzer_d;
         busy_q      <= busy_d;
      end
   end

   assign led_err_o  = led_err_q;
   assign led_off_o  = led_off_q;
   assign led_on_o   = led_on_q;
   assign led_open_o = led_open_q;
   assign buzzer_o   = buzzer_q;
   assign busy_o     = busy_q;

endmodule
